// File: rtl/alarm_clk_alarm_ctrl_if.sv
// Avalon-MM slave register bus for the alarm controller.
// readdata is driven combinationally by the slave (read latency 0).
interface alarm_clk_alarm_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/alarm_clk_alarm_ctrl.sv
// Alarm controller: compares time of day to ALARM_TIME, rings/snoozes the buzzer.
// Optional macro ALARM_CTRL_IRQ_EN enables the irq_pending flag and irq output.
module alarm_clk_alarm_ctrl #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sec_tick,
    input  logic [16:0]                 time_now,
    alarm_clk_alarm_ctrl_if.slave       bus,
    output logic                        out_port,
    output logic                        irq
);

    localparam int unsigned TIME_W   = 17;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DAY_SECS = 86400;
    localparam int unsigned RING_W   = (RING_SECS < 2) ? 1 : $clog2(RING_SECS + 1);
    localparam int unsigned SNZ_W    = (SNOOZE_SECS < 2) ? 1 : $clog2(SNOOZE_SECS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t              state;
    logic [TIME_W-1:0]   alarm_time;
    logic                en;
    logic [RING_W-1:0]   ring_cnt;
    logic [SNZ_W-1:0]    snz_cnt;

    logic wr_c;
    logic wr_alarm_c;
    logic wr_ctrl_c;
    logic ctrl_en_c;
    logic ctrl_snooze_c;
    logic ctrl_stop_c;
    logic ctrl_takes_c;
    logic time_match_c;
    logic ring_start_c;
    logic irq_bit_c;
    logic unused_c;

    assign wr_c          = bus.chipselect && !bus.write_n;
    assign wr_alarm_c    = wr_c && (bus.address == 2'd0);
    assign wr_ctrl_c     = wr_c && (bus.address == 2'd1);
    assign ctrl_en_c     = bus.writedata[0];
    assign ctrl_snooze_c = bus.writedata[1];
    assign ctrl_stop_c   = bus.writedata[2];
    assign unused_c      = ^bus.writedata[31:17];

    // A CTRL write that changes state pre-empts any tick-driven transition on the same edge
    assign ctrl_takes_c = wr_ctrl_c &&
                          (!ctrl_en_c ||
                           (state == IDLE) ||
                           (ctrl_stop_c && ((state == RINGING) || (state == SNOOZE))) ||
                           (ctrl_snooze_c && (state == RINGING)));

    // Out-of-range alarm times are stored but can never match
    assign time_match_c = (alarm_time < TIME_W'(DAY_SECS)) && (time_now == alarm_time);

    assign ring_start_c = !ctrl_takes_c && sec_tick &&
                          (((state == ARMED) && time_match_c) ||
                           ((state == SNOOZE) && (snz_cnt <= SNZ_W'(1))));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alarm_time <= '0;
            en         <= 1'b0;
        end else begin
            if (wr_alarm_c) begin
                alarm_time <= bus.writedata[TIME_W-1:0];
            end
            if (wr_ctrl_c) begin
                en <= ctrl_en_c;
            end
        end
    end

    // Alarm FSM with registered buzzer output and second counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            out_port <= 1'b0;
        end else if (wr_ctrl_c && !ctrl_en_c) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            out_port <= 1'b0;
        end else if (wr_ctrl_c && (state == IDLE)) begin
            state    <= ARMED;
        end else if (wr_ctrl_c && ctrl_stop_c && ((state == RINGING) || (state == SNOOZE))) begin
            state    <= ARMED;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            out_port <= 1'b0;
        end else if (wr_ctrl_c && ctrl_snooze_c && (state == RINGING)) begin
            state    <= SNOOZE;
            ring_cnt <= '0;
            snz_cnt  <= SNZ_W'(SNOOZE_SECS);
            out_port <= 1'b0;
        end else if (ring_start_c) begin
            state    <= RINGING;
            ring_cnt <= RING_W'(RING_SECS);
            snz_cnt  <= '0;
            out_port <= 1'b1;
        end else if (sec_tick && (state == RINGING)) begin
            if (ring_cnt <= RING_W'(1)) begin
                state    <= ARMED;
                ring_cnt <= '0;
                out_port <= 1'b0;
            end else begin
                ring_cnt <= ring_cnt - RING_W'(1);
                out_port <= !out_port;
            end
        end else if (sec_tick && (state == SNOOZE)) begin
            snz_cnt  <= snz_cnt - SNZ_W'(1);
        end
    end

`ifdef ALARM_CTRL_IRQ_EN
    logic irq_pending;
    logic wr_irqclr_c;

    assign wr_irqclr_c = wr_c && (bus.address == 2'd3);

    // A ring start on the same edge wins over the software clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_pending <= 1'b0;
        end else if (ring_start_c) begin
            irq_pending <= 1'b1;
        end else if (wr_irqclr_c) begin
            irq_pending <= 1'b0;
        end
    end

    assign irq       = irq_pending;
    assign irq_bit_c = irq_pending;
`else
    assign irq       = 1'b0;
    assign irq_bit_c = 1'b0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = DATA_W'(alarm_time);
            2'd1:    bus.readdata = DATA_W'(en);
            2'd2:    bus.readdata = DATA_W'({irq_bit_c, out_port, state});
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_alarm_clk_alarm_ctrl.sv
// Bench for alarm_clk_alarm_ctrl: directed vector table, hand sequences, random vs. reference model.
module tb_alarm_clk_alarm_ctrl;

    localparam int unsigned RING   = 4;
    localparam int unsigned SNOOZE = 3;
`ifdef ALARM_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        sec_tick;
    logic [16:0] time_now;
    logic        out_port;
    logic        irq;

    alarm_clk_alarm_ctrl_if bus ();

    alarm_clk_alarm_ctrl #(
        .RING_SECS   (RING),
        .SNOOZE_SECS (SNOOZE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sec_tick (sec_tick),
        .time_now (time_now),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = !clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ring/snooze progress tracked as elapsed seconds
    int          m_mode;
    int          m_ring_el;
    int          m_snz_el;
    int          m_alarm;
    bit          m_en;
    bit          m_irq;

    task automatic model_edge(input bit rst_n, input bit cs, input bit wn, input int addr,
                              input logic [31:0] wd, input bit tick, input int tnow);
        bit wr;
        bit ctrl;
        bit set;
        int old_alarm;
        if (!rst_n) begin
            m_mode = 0; m_ring_el = 0; m_snz_el = 0; m_alarm = 0; m_en = 0; m_irq = 0;
            return;
        end
        wr        = cs && !wn;
        ctrl      = wr && (addr == 1);
        set       = 1'b0;
        old_alarm = m_alarm;
        if (wr && addr == 0) m_alarm = int'(wd[16:0]);
        if (ctrl) m_en = wd[0];
        if (ctrl && !wd[0]) m_mode = 0;
        else if (ctrl && m_mode == 0) m_mode = 1;
        else if (ctrl && wd[2] && m_mode >= 2) m_mode = 1;
        else if (ctrl && wd[1] && m_mode == 2) begin
            m_mode = 3; m_snz_el = 0;
        end else if (tick) begin
            if (m_mode == 1 && old_alarm < 86400 && tnow == old_alarm) begin
                m_mode = 2; m_ring_el = 0; set = 1'b1;
            end else if (m_mode == 2) begin
                m_ring_el++;
                if (m_ring_el >= int'(RING)) m_mode = 1;
            end else if (m_mode == 3) begin
                m_snz_el++;
                if (m_snz_el >= int'(SNOOZE)) begin
                    m_mode = 2; m_ring_el = 0; set = 1'b1;
                end
            end
        end
        if (IRQ_ON) begin
            if (set) m_irq = 1'b1;
            else if (wr && addr == 3) m_irq = 1'b0;
        end
    endtask

    function automatic bit m_out();
        return (m_mode == 2) && (m_ring_el % 2 == 0);
    endfunction

    function automatic logic [31:0] m_read(input int addr);
        case (addr)
            0:       return 32'(m_alarm);
            1:       return 32'(m_en);
            2:       return {28'd0, m_irq, m_out(), 2'(m_mode)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd2;
        bus.writedata  = 32'd0;
        sec_tick       = 1'b0;
    endtask

    // One clock: present inputs, take the edge, return bus to idle STATUS read
    task automatic cycle(input bit cs, input bit wn, input logic [1:0] addr,
                         input logic [31:0] wd, input bit tick, input logic [16:0] tnow);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = addr;
        bus.writedata  = wd;
        sec_tick       = tick;
        time_now       = tnow;
        @(posedge clk);
        #1;
        bus_idle();
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] wd);
        cycle(1'b1, 1'b0, addr, wd, 1'b0, time_now);
    endtask

    task automatic tick(input logic [16:0] tnow);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b1, tnow);
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
        bus.address = 2'd2;
        #1;
    endtask

    typedef struct {
        bit          cs;
        bit          wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        bit          tick;
        logic [16:0] tnow;
        logic [1:0]  exp_state;
        bit          exp_out;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] rd;
        bit          r_rst;
        bit          r_cs;
        bit          r_wn;
        logic [1:0]  r_addr;
        logic [31:0] r_wd;
        bit          r_tick;
        logic [16:0] r_tnow;

        vecs[0]  = '{1, 0, 2'd0, 32'd100, 0, 17'd0,   2'd0, 0};
        vecs[1]  = '{1, 0, 2'd1, 32'h1,   0, 17'd0,   2'd1, 0};
        vecs[2]  = '{0, 1, 2'd0, 32'd0,   1, 17'd99,  2'd1, 0};
        vecs[3]  = '{0, 1, 2'd0, 32'd0,   1, 17'd100, 2'd2, 1};
        vecs[4]  = '{0, 1, 2'd0, 32'd0,   0, 17'd100, 2'd2, 1};
        vecs[5]  = '{0, 1, 2'd0, 32'd0,   1, 17'd101, 2'd2, 0};
        vecs[6]  = '{0, 1, 2'd0, 32'd0,   1, 17'd102, 2'd2, 1};
        vecs[7]  = '{0, 1, 2'd0, 32'd0,   1, 17'd103, 2'd2, 0};
        vecs[8]  = '{0, 1, 2'd0, 32'd0,   1, 17'd104, 2'd1, 0};
        vecs[9]  = '{0, 1, 2'd0, 32'd0,   1, 17'd100, 2'd2, 1};
        vecs[10] = '{1, 0, 2'd1, 32'h3,   1, 17'd101, 2'd3, 0};
        vecs[11] = '{0, 1, 2'd0, 32'd0,   1, 17'd102, 2'd3, 0};
        vecs[12] = '{0, 1, 2'd0, 32'd0,   1, 17'd103, 2'd3, 0};
        vecs[13] = '{0, 1, 2'd0, 32'd0,   1, 17'd104, 2'd2, 1};
        vecs[14] = '{1, 0, 2'd1, 32'h5,   1, 17'd105, 2'd1, 0};
        vecs[15] = '{0, 1, 2'd0, 32'd0,   1, 17'd100, 2'd2, 1};
        vecs[16] = '{1, 0, 2'd1, 32'h6,   1, 17'd101, 2'd0, 0};
        vecs[17] = '{0, 1, 2'd0, 32'd0,   1, 17'd100, 2'd0, 0};

        bus_idle();
        time_now = 17'd0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out_port), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'd0);
        end
        reset_n = 1'b1;

        // Directed table: arm, ring pattern, expiry, snooze, stop, disable
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd, vecs[i].tick, vecs[i].tnow);
            check($sformatf("vec%0d_state", i), 32'(bus.readdata[1:0]), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
        end

        // IRQ set, clear, and clear-vs-set on the same edge
        wr_reg(2'd1, 32'h1);
        tick(17'd100);
        check("irq_on_ring", 32'(irq), 32'(IRQ_ON));
        rd_reg(2'd2, rd);
        check("status_ring", rd, {28'd0, IRQ_ON, 1'b1, 2'd2});
        wr_reg(2'd3, 32'd0);
        check("irq_cleared", 32'(irq), 32'd0);
        wr_reg(2'd1, 32'h3);
        cycle(1'b1, 1'b0, 2'd3, 32'd0, 1'b0, 17'd0);
        repeat (2) tick(17'd5);
        cycle(1'b1, 1'b0, 2'd3, 32'd0, 1'b1, 17'd5);
        check("irq_clr_loses", 32'(irq), 32'(IRQ_ON));
        check("resnooze_state", 32'(bus.readdata[1:0]), 32'd2);
        check("resnooze_out", 32'(out_port), 32'd1);

        // Reset mid-ring overrides a same-cycle write
        reset_n = 1'b0;
        cycle(1'b1, 1'b0, 2'd0, 32'd55, 1'b1, 17'd100);
        reset_n = 1'b1;
        check("midring_rst_out", 32'(out_port), 32'd0);
        check("midring_rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 3; a++) begin
            rd_reg(2'(a), rd);
            check($sformatf("midring_rst_reg%0d", a), rd, 32'd0);
        end

        // Out-of-range alarm never matches; STOP/SNOOZE ignored while armed
        wr_reg(2'd0, 32'd90000);
        wr_reg(2'd1, 32'h1);
        wr_reg(2'd1, 32'h7);
        tick(17'd90000);
        tick(17'(90000 - 86400));
        tick(17'd0);
        rd_reg(2'd0, rd);
        check("alarm_stored", rd, 32'd90000);
        check("never_rings_state", 32'(bus.readdata[1:0]), 32'd1);
        check("never_rings_out", 32'(out_port), 32'd0);

        // Random traffic against the reference model
        reset_n = 1'b0;
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 17'd0);
        model_edge(1'b0, 1'b0, 1'b1, 0, 32'd0, 1'b0, 0);
        for (int i = 0; i < 4000; i++) begin
            r_rst  = ($urandom_range(0, 299) != 0);
            r_cs   = 1'($urandom_range(0, 1));
            r_wn   = ($urandom_range(0, 2) != 0);
            r_addr = 2'($urandom_range(0, 3));
            r_wd   = $urandom;
            if (r_addr == 2'd0) begin
                r_wd[16:0] = ($urandom_range(0, 8) == 8) ? 17'd90000 : 17'($urandom_range(0, 7));
            end else if (r_addr == 2'd1) begin
                r_wd[0] = ($urandom_range(0, 7) != 0);
                r_wd[1] = ($urandom_range(0, 3) == 0);
                r_wd[2] = ($urandom_range(0, 5) == 0);
            end
            r_tick = 1'($urandom_range(0, 1));
            r_tnow = ($urandom_range(0, 30) == 0) ? 17'd90000 : 17'($urandom_range(0, 7));

            reset_n        = r_rst;
            bus.chipselect = r_cs;
            bus.write_n    = r_wn;
            bus.address    = r_addr;
            bus.writedata  = r_wd;
            sec_tick       = r_tick;
            time_now       = r_tnow;
            @(posedge clk);
            model_edge(r_rst, r_cs, r_wn, int'(r_addr), r_wd, r_tick, int'(r_tnow));
            #1;
            check("rnd_out", 32'(out_port), 32'(m_out()));
            check("rnd_irq", 32'(irq), 32'(m_irq));
            check("rnd_readdata", bus.readdata, m_read(int'(r_addr)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
